// File: rtl/digit_scan_sequencer_pkg.sv
// Shared definitions for the digit scan sequencer: FSM state encodings and digit geometry.
package digit_scan_sequencer_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_BLANK  = 2'd2
  } state_t;

endpackage

// File: rtl/digit_scan_sequencer_next_sel.sv
// Combinational digit picker: next enabled digit above idx (wrapping), lowest enabled digit,
// wrap flag for frame accounting, and whether the current digit is still enabled.
module digit_next_sel
  import digit_scan_sequencer_pkg::*;
(
  input  logic [IDX_W-1:0]      idx,
  input  logic [NUM_DIGITS-1:0] mask,
  output logic [IDX_W-1:0]      nxt,
  output logic                  wrap,
  output logic [IDX_W-1:0]      first,
  output logic                  cur_valid
);

  // Scan offsets from far to near so the nearest enabled digit wins; offset 0 (== idx)
  // is the fallback when idx is the only enabled digit.
  always_comb begin
    logic [IDX_W-1:0] cand;
    nxt  = idx;
    cand = idx;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      cand = idx + IDX_W'(k);
      if (mask[cand]) nxt = cand;
    end
  end

  always_comb begin
    first = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask[i]) first = IDX_W'(i);
    end
  end

  assign wrap      = (nxt <= idx);
  assign cur_valid = mask[idx];

endmodule

// File: rtl/digit_scan_sequencer.sv
// Four-digit scan sequencer driving a 2-to-4 enabled decoder with digit/frame strobes.
// Define SCAN_BLANK_EN to insert BLANK_CYCLES of decoder-disable between digits.
module digit_scan_sequencer
  import digit_scan_sequencer_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic                  sel_a,
  output logic                  sel_b,
  output logic                  en,
  output logic                  digit_strobe,
  output logic                  frame_done
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             strobe_q, strobe_d;
  logic             frame_q, frame_d;

  logic [IDX_W-1:0] nxt, first;
  logic             wrap, cur_valid, cnt_last;

  digit_next_sel u_next_sel (
    .idx       (idx_q),
    .mask      (digit_mask),
    .nxt       (nxt),
    .wrap      (wrap),
    .first     (first),
    .cur_valid (cur_valid)
  );

  assign cnt_last = (cnt_q == ((state_q == S_BLANK) ? CNT_W'(BLANK_CYCLES - 1)
                                                      : CNT_W'(TICK_DIV - 1)));

  // Outputs are registered copies of what the next state implies, so en/strobes
  // line up with the cycle in which the new state is live.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    en_d     = 1'b0;
    strobe_d = 1'b0;
    frame_d  = 1'b0;
    if (!run || digit_mask == '0) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_ACTIVE;
          idx_d    = first;
          cnt_d    = '0;
          en_d     = 1'b1;
          strobe_d = 1'b1;
        end
        S_ACTIVE: begin
          // A digit dropped from the mask is abandoned at once so en never shows it.
          if (cnt_last || !cur_valid) begin
            idx_d   = nxt;
            cnt_d   = '0;
            frame_d = wrap;
`ifdef SCAN_BLANK_EN
            state_d = S_BLANK;
`else
            en_d     = 1'b1;
            strobe_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
            en_d  = 1'b1;
          end
        end
`ifdef SCAN_BLANK_EN
        S_BLANK: begin
          if (cnt_last) begin
            state_d  = S_ACTIVE;
            cnt_d    = '0;
            en_d     = 1'b1;
            strobe_d = 1'b1;
            if (!cur_valid) idx_d = nxt;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      strobe_q <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      strobe_q <= strobe_d;
      frame_q  <= frame_d;
    end
  end

  assign sel_a        = idx_q[1];
  assign sel_b        = idx_q[0];
  assign en           = en_q;
  assign digit_strobe = strobe_q;
  assign frame_done   = frame_q;

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Randomized self-checking bench for digit_scan_sequencer against a dwell-countdown model.
module tb_digit_scan_sequencer;

  localparam int TICK  = 4;
  localparam int BLANK = 2;
`ifdef SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] digit_mask;
  logic       sel_a, sel_b, en, digit_strobe, frame_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: scanning on/off, showing vs blanking, digit number, cycles left in phase.
  bit       m_on, m_blank;
  int       m_digit, m_left;
  bit       x_en, x_strobe, x_frame;
  bit [3:0] prev_mask;

  digit_scan_sequencer #(
    .TICK_DIV     (TICK),
    .BLANK_CYCLES (BLANK),
    .CNT_W        (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .digit_mask   (digit_mask),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .en           (en),
    .digit_strobe (digit_strobe),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [3:0] mk);
    for (int i = 0; i < 4; i++) if (mk[i]) return i;
    return 0;
  endfunction

  function automatic int next_digit(input bit [3:0] mk, input int d);
    for (int k = 1; k <= 4; k++) if (mk[(d + k) % 4]) return (d + k) % 4;
    return d;
  endfunction

  task automatic model_reset();
    m_on = 0; m_blank = 0; m_digit = 0; m_left = 0;
    x_en = 0; x_strobe = 0; x_frame = 0;
  endtask

  task automatic model_edge(input bit r, input bit [3:0] mk);
    int n;
    x_en = 0; x_strobe = 0; x_frame = 0;
    if (!r || mk == 0) begin
      m_on = 0;
    end else if (!m_on) begin
      m_on = 1; m_blank = 0; m_digit = lowest(mk); m_left = TICK;
      x_en = 1; x_strobe = 1;
    end else if (!m_blank) begin
      if (m_left == 1 || !mk[m_digit]) begin
        n = next_digit(mk, m_digit);
        x_frame = (n <= m_digit);
        m_digit = n;
        if (BLANK_ON) begin
          m_blank = 1; m_left = BLANK;
        end else begin
          m_left = TICK; x_en = 1; x_strobe = 1;
        end
      end else begin
        m_left--; x_en = 1;
      end
    end else begin
      if (m_left == 1) begin
        m_blank = 0; m_left = TICK; x_en = 1; x_strobe = 1;
        if (!mk[m_digit]) m_digit = next_digit(mk, m_digit);
      end else begin
        m_left--;
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_en"}, en, x_en);
    chk({ph, "_sel"}, {sel_a, sel_b}, m_digit[1:0]);
    chk({ph, "_strobe"}, digit_strobe, x_strobe);
    chk({ph, "_frame"}, frame_done, x_frame);
    chk({ph, "_inv"}, (en && !prev_mask[{sel_a, sel_b}]) ? 0 : 1, 1);
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(run, digit_mask);
    prev_mask = digit_mask;
    #1;
    check_outputs(ph);
  endtask

  task automatic phase(input string ph, input bit r, input bit [3:0] mk, input int n);
    int strobes = 0, frames = 0;
    run = r; digit_mask = mk;
    for (int i = 0; i < n; i++) begin
      step(ph);
      strobes += digit_strobe;
      frames  += frame_done;
    end
    $display("phase %s run=%0b mask=%b cycles=%0d strobes=%0d frames=%0d", ph, r, mk, n, strobes, frames);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; run = 1'b0; digit_mask = 4'b0; prev_mask = 4'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
    phase("idle_after_reset", 1'b0, 4'b1111, 4);

    phase("all_digits", 1'b1, 4'b1111, 40);

    // Asynchronous reset landing mid-cycle during a scan.
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    run = 1'b0;
    step("rst_hold");
    #1 rst_n = 1'b1;
    phase("post_rst_stopped", 1'b0, 4'b1111, 3);

    phase("mask_1010", 1'b1, 4'b1010, 30);
    phase("stop", 1'b0, 4'b1010, 2);
    phase("single_0100", 1'b1, 4'b0100, 20);
    phase("mask_zero", 1'b1, 4'b0000, 3);

    // Drop the live digit 1 mid-dwell, then stop exactly on a terminal-count edge.
    phase("start_on_1", 1'b1, 4'b1110, 2);
    phase("drop_bit1", 1'b1, 4'b1100, 3);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_on && !m_blank && m_left == 1) found = 1;
      else step("seek_term");
    end
    chk("seek_term_bound", found, 1);
    phase("stop_at_term", 1'b0, 4'b1100, 2);

    run = 1'b1; digit_mask = 4'b1111;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0) digit_mask = 4'($urandom_range(15));
      if ($urandom_range(40) == 0) run = ~run;
      step("random");
    end
    $display("phase random done checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
